// File: rtl/machv_uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package machv_uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        NEXT = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ      = 2;
    localparam int DEF_LOCK_TIMEOUT = 1000000;

    // A timeout of one still needs a one-bit counter register.
    function automatic int cnt_width(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-core-side signals of the transmit arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if
    import machv_uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);

    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]   REQ_LAST;
    logic [NUM_REQ-1:0]   REQ_READY;
    logic [7:0]           TX_DATA;
    logic                 TX_STB;
    logic                 TX_ACK;
    logic [NUM_REQ-1:0]   GRANT;
    logic                 BUSY;
    logic                 TIMEOUT;

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, TX_ACK,
        output REQ_READY, TX_DATA, TX_STB, GRANT, BUSY, TIMEOUT
    );

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, TX_ACK,
        input  REQ_READY, TX_DATA, TX_STB, GRANT, BUSY, TIMEOUT
    );

endinterface

// File: rtl/machv_rr_pick.sv
// Combinational round-robin picker: the first asserted request found when
// scanning upward from i_start, wrapping modulo N.
module machv_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    logic [IW-1:0] w_idx;

    // Scan every position once from the start index and keep the first hit.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IW'((int'(i_start) + k) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte requesters onto one UART transmit core.
// A message (bytes up to the one flagged LAST) keeps the grant locked to its
// owner; an owner that goes quiet for LOCK_TIMEOUT cycles loses the grant.
module uart_tx_arbiter
    import machv_uart_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input logic              CLK,
    input logic              RESET,
    uart_tx_arbiter_if.slave bus
);

    localparam int              IW      = $clog2(NUM_REQ);
    localparam int              CNTW    = cnt_width(LOCK_TIMEOUT);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(LOCK_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        r_last_owner;
    logic [IW-1:0]        w_start;
    logic [IW-1:0]        w_pick_idx;
    logic [IW-1:0]        w_sel_idx;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 w_pick_valid;
    logic                 w_xfer;
    logic                 w_ack_done;
    logic                 w_expire;
    logic                 w_sel_last;
    logic                 r_locked;
    logic                 r_tx_stb;
    logic                 r_timeout;
    logic [7:0]           r_tx_data;
    logic [7:0]           w_sel_data;
    logic [CNTW-1:0]      r_cnt;

    assign w_start    = (r_last_owner == IW'(NUM_REQ - 1)) ? '0 : r_last_owner + IW'(1);
    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

    machv_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req   (bus.REQ_VALID),
        .i_start (w_start),
        .o_grant (w_pick_oh),
        .o_valid (w_pick_valid)
    );

    // Convert the one-hot winner into an index for owner bookkeeping.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_oh[i]) begin
                w_pick_idx = IW'(i);
            end
        end
    end

    // Select the byte and LAST flag of whichever requester is being served.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_idx == IW'(i)) begin
                w_sel_data = bus.REQ_DATA[8*i +: 8];
                w_sel_last = bus.REQ_LAST[i];
            end
        end
    end

    // State register; reset parks the arbiter in IDLE immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; a transfer in NEXT beats counter expiry.
    always_comb begin
        w_next_state = r_state;
        w_ready      = '0;
        w_sel_idx    = w_pick_idx;
        w_xfer       = 1'b0;
        w_ack_done   = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready   = w_pick_oh;
                w_sel_idx = w_pick_idx;
                if (w_pick_valid) begin
                    w_xfer       = 1'b1;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (bus.TX_ACK) begin
                    w_ack_done   = 1'b1;
                    w_next_state = r_locked ? NEXT : IDLE;
                end
            end
            NEXT: begin
                w_ready   = w_owner_oh;
                w_sel_idx = r_owner;
                if (bus.REQ_VALID[r_owner]) begin
                    w_xfer       = 1'b1;
                    w_next_state = SEND;
                end else if (r_cnt == CNT_MAX) begin
                    w_expire     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture accepted bytes, track ownership, lock and idle counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tx_data    <= 8'h00;
            r_tx_stb     <= 1'b0;
            r_owner      <= '0;
            r_last_owner <= IW'(NUM_REQ - 1);
            r_locked     <= 1'b0;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_xfer) begin
                r_tx_data <= w_sel_data;
                r_tx_stb  <= 1'b1;
                r_owner   <= w_sel_idx;
                r_locked  <= !w_sel_last;
            end
            if (w_ack_done) begin
                r_tx_stb <= 1'b0;
                r_cnt    <= '0;
                if (!r_locked) begin
                    r_last_owner <= r_owner;
                end
            end
            if (w_expire) begin
                r_last_owner <= r_owner;
                r_locked     <= 1'b0;
                r_cnt        <= '0;
            end else if (r_state == NEXT && !w_xfer) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign bus.REQ_READY = w_ready;
    assign bus.TX_DATA   = r_tx_data;
    assign bus.TX_STB    = r_tx_stb;
    assign bus.GRANT     = (r_state != IDLE) ? w_owner_oh : '0;
    assign bus.BUSY      = (r_state != IDLE);
    assign bus.TIMEOUT   = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with two requesters and a short
// lock timeout. Expected bytes and grants are queued when a test queues the
// stimulus and popped as the UART side sees each strobe.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } rbyte_t;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] g;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    int     checks   = 0;
    int     failures = 0;
    rbyte_t rq0[$];
    rbyte_t rq1[$];
    exp_t   sbq[$];

    uart_tx_arbiter_if #(.NUM_REQ(2)) bus();

    uart_tx_arbiter #(
        .NUM_REQ      (2),
        .LOCK_TIMEOUT (16)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive each requester's head-of-queue byte; an empty queue drops VALID.
    task automatic present();
        bus.REQ_VALID = {rq1.size() != 0, rq0.size() != 0};
        bus.REQ_DATA  = {(rq1.size() != 0) ? rq1[0].d : 8'h00, (rq0.size() != 0) ? rq0[0].d : 8'h00};
        bus.REQ_LAST  = {(rq1.size() != 0) ? rq1[0].l : 1'b0, (rq0.size() != 0) ? rq0[0].l : 1'b0};
    endtask

    // Advance one clock from negedge+1 to the next negedge+1; READY is
    // sampled 1 ns before the rising edge and accepted bytes are retired.
    task automatic tick(output logic [1:0] rdy);
        logic [1:0] xfer;
        #3;
        rdy  = bus.REQ_READY;
        xfer = bus.REQ_VALID & rdy;
        @(negedge clk);
        if (xfer[0] && rq0.size() != 0) void'(rq0.pop_front());
        if (xfer[1] && rq1.size() != 0) void'(rq1.pop_front());
        present();
        #1;
    endtask

    // UART-core model: wait (bounded) for a strobe, capture it, ack dly cycles after it rose.
    task automatic serve_one(input int dly, output logic [7:0] d, output logic [1:0] g,
                             output logic [1:0] rdyOr, output int lat, output bit ok);
        logic [1:0] r;
        ok = 1'b0; rdyOr = '0; lat = 0; d = '0; g = '0;
        for (int i = 0; i < 64; i++) begin
            if (bus.TX_STB) begin
                ok = 1'b1;
                break;
            end
            tick(r); rdyOr |= r; lat++;
        end
        if (!ok) return;
        d = bus.TX_DATA;
        g = bus.GRANT;
        for (int i = 0; i < dly - 1; i++) begin
            tick(r); rdyOr |= r;
        end
        bus.TX_ACK = 1'b1;
        tick(r); rdyOr |= r;
        bus.TX_ACK = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.TX_ACK = 1'b0;
        present();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.TX_STB !== 1'b0) begin failures++; $display("[TB] FAIL reset_stb got=%b exp=0", bus.TX_STB); end
        checks++; if (bus.TX_DATA !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", bus.TX_DATA); end
        checks++; if (bus.GRANT !== 2'b00) begin failures++; $display("[TB] FAIL reset_grant got=%b exp=00", bus.GRANT); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.BUSY); end
        checks++; if (bus.TIMEOUT !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout got=%b exp=0", bus.TIMEOUT); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [7:0] d; logic [1:0] g; logic [1:0] rOr; int lat; bit ok; exp_t e;
        rq0.push_back({8'h41, 1'b1}); rq1.push_back({8'h42, 1'b1});
        sbq.push_back({8'h41, 2'b01}); sbq.push_back({8'h42, 2'b10});
        present();
        for (int n = 0; n < 2; n++) begin
            serve_one(3, d, g, rOr, lat, ok);
            checks++; if (!ok) begin failures++; $display("[TB] FAIL rr_stb_timeout byte=%0d got=no strobe exp=strobe", n); end
            checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL rr_latency byte=%0d got=%0d exp=1", n, lat); end
            e = (sbq.size() != 0) ? sbq.pop_front() : '0;
            checks++; if (d !== e.d) begin failures++; $display("[TB] FAIL rr_data byte=%0d got=%h exp=%h", n, d, e.d); end
            checks++; if (g !== e.g) begin failures++; $display("[TB] FAIL rr_grant byte=%0d got=%b exp=%b", n, g, e.g); end
            checks++; if (rOr !== e.g) begin failures++; $display("[TB] FAIL rr_ready byte=%0d got=%b exp=%b", n, rOr, e.g); end
            checks++; if (bus.TX_STB !== 1'b0) begin failures++; $display("[TB] FAIL rr_stb_drop byte=%0d got=%b exp=0", n, bus.TX_STB); end
        end
    endtask

    task automatic test_lock();
        logic [7:0] d; logic [1:0] g; logic [1:0] rOr; int lat; bit ok; exp_t e;
        rq0.push_back({8'h41, 1'b0}); rq0.push_back({8'h42, 1'b0}); rq0.push_back({8'h43, 1'b1});
        rq1.push_back({8'h5A, 1'b1});
        sbq.push_back({8'h41, 2'b01}); sbq.push_back({8'h42, 2'b01});
        sbq.push_back({8'h43, 2'b01}); sbq.push_back({8'h5A, 2'b10});
        present();
        for (int n = 0; n < 4; n++) begin
            serve_one(2, d, g, rOr, lat, ok);
            checks++; if (!ok) begin failures++; $display("[TB] FAIL lock_stb_timeout byte=%0d got=no strobe exp=strobe", n); end
            e = (sbq.size() != 0) ? sbq.pop_front() : '0;
            checks++; if (d !== e.d) begin failures++; $display("[TB] FAIL lock_data byte=%0d got=%h exp=%h", n, d, e.d); end
            checks++; if (g !== e.g) begin failures++; $display("[TB] FAIL lock_grant byte=%0d got=%b exp=%b", n, g, e.g); end
            if (n < 3) begin
                checks++; if (rOr[1] !== 1'b0) begin failures++; $display("[TB] FAIL lock_starve byte=%0d got=%b exp=0", n, rOr[1]); end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d; logic [1:0] g; logic [1:0] rOr; logic [1:0] r; int lat; bit ok; exp_t e;
        int first; int pulses; logic busy16; logic [1:0] grant16;
        rq0.push_back({8'h61, 1'b0});
        sbq.push_back({8'h61, 2'b01});
        present();
        serve_one(2, d, g, rOr, lat, ok);
        e = (sbq.size() != 0) ? sbq.pop_front() : '0;
        checks++; if (!ok || d !== e.d || g !== e.g) begin failures++; $display("[TB] FAIL tmo_first_byte got=%h/%b exp=%h/%b", d, g, e.d, e.g); end
        rq1.push_back({8'h62, 1'b1});
        sbq.push_back({8'h62, 2'b10});
        present();
        first = 0; pulses = 0; rOr = '0; busy16 = 1'bx; grant16 = 'x;
        for (int k = 1; k <= 16; k++) begin
            tick(r); rOr |= r;
            if (bus.TIMEOUT === 1'b1) begin
                if (first == 0) first = k;
                pulses++;
            end
            if (k == 16) begin busy16 = bus.BUSY; grant16 = bus.GRANT; end
        end
        checks++; if (first !== 16) begin failures++; $display("[TB] FAIL tmo_cycle got=%0d exp=16", first); end
        checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL tmo_pulses got=%0d exp=1", pulses); end
        checks++; if (busy16 !== 1'b0) begin failures++; $display("[TB] FAIL tmo_busy got=%b exp=0", busy16); end
        checks++; if (grant16 !== 2'b00) begin failures++; $display("[TB] FAIL tmo_grant_idle got=%b exp=00", grant16); end
        checks++; if (rOr[1] !== 1'b0) begin failures++; $display("[TB] FAIL tmo_starve got=%b exp=0", rOr[1]); end
        tick(r);
        checks++; if (r !== 2'b10) begin failures++; $display("[TB] FAIL tmo_next_ready got=%b exp=10", r); end
        checks++; if (bus.TIMEOUT !== 1'b0) begin failures++; $display("[TB] FAIL tmo_one_cycle got=%b exp=0", bus.TIMEOUT); end
        serve_one(2, d, g, rOr, lat, ok);
        e = (sbq.size() != 0) ? sbq.pop_front() : '0;
        checks++; if (!ok || lat !== 0) begin failures++; $display("[TB] FAIL tmo_req1_latency got=%0d exp=0", lat); end
        checks++; if (d !== e.d || g !== e.g) begin failures++; $display("[TB] FAIL tmo_req1_byte got=%h/%b exp=%h/%b", d, g, e.d, e.g); end
    endtask

    task automatic test_ack_idle();
        logic [1:0] r; exp_t e; int stbHigh;
        bus.TX_ACK = 1'b1;
        repeat (3) tick(r);
        checks++; if (bus.TX_STB !== 1'b0 || bus.BUSY !== 1'b0) begin failures++; $display("[TB] FAIL ackidle_quiet got=%b%b exp=00", bus.TX_STB, bus.BUSY); end
        rq0.push_back({8'h55, 1'b1});
        sbq.push_back({8'h55, 2'b01});
        present();
        tick(r);
        e = (sbq.size() != 0) ? sbq.pop_front() : '0;
        checks++; if (bus.TX_STB !== 1'b1) begin failures++; $display("[TB] FAIL ackidle_stb_rise got=%b exp=1", bus.TX_STB); end
        checks++; if (bus.TX_DATA !== e.d || bus.GRANT !== e.g) begin failures++; $display("[TB] FAIL ackidle_byte got=%h/%b exp=%h/%b", bus.TX_DATA, bus.GRANT, e.d, e.g); end
        tick(r);
        checks++; if (bus.TX_STB !== 1'b0 || bus.BUSY !== 1'b0) begin failures++; $display("[TB] FAIL ackidle_stb_fall got=%b%b exp=00", bus.TX_STB, bus.BUSY); end
        bus.TX_ACK = 1'b0;
        stbHigh = 0;
        repeat (4) begin
            tick(r);
            if (bus.TX_STB !== 1'b0) stbHigh++;
        end
        checks++; if (stbHigh !== 0) begin failures++; $display("[TB] FAIL ackidle_single_byte got=%0d extra strobe cycles exp=0", stbHigh); end
    endtask

    task automatic test_reset_mid_send();
        logic [7:0] d; logic [1:0] g; logic [1:0] rOr; logic [1:0] r; int lat; bit ok; exp_t e;
        rq0.push_back({8'h70, 1'b1});
        present();
        tick(r);
        tick(r);
        checks++; if (bus.TX_STB !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre_stb got=%b exp=1", bus.TX_STB); end
        rst = 1'b1;
        #1;
        checks++; if (bus.TX_STB !== 1'b0) begin failures++; $display("[TB] FAIL midrst_stb got=%b exp=0", bus.TX_STB); end
        checks++; if (bus.GRANT !== 2'b00) begin failures++; $display("[TB] FAIL midrst_grant got=%b exp=00", bus.GRANT); end
        checks++; if (bus.BUSY !== 1'b0 || bus.TX_DATA !== 8'h00) begin failures++; $display("[TB] FAIL midrst_busy_data got=%b/%h exp=0/00", bus.BUSY, bus.TX_DATA); end
        @(negedge clk); #1;
        rq0.push_back({8'h81, 1'b1}); rq1.push_back({8'h82, 1'b1});
        sbq.push_back({8'h81, 2'b01}); sbq.push_back({8'h82, 2'b10});
        present();
        @(negedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            serve_one(2, d, g, rOr, lat, ok);
            e = (sbq.size() != 0) ? sbq.pop_front() : '0;
            checks++; if (!ok || d !== e.d || g !== e.g) begin failures++; $display("[TB] FAIL midrst_order byte=%0d got=%h/%b exp=%h/%b", n, d, g, e.d, e.g); end
            checks++; if (rOr !== e.g) begin failures++; $display("[TB] FAIL midrst_ready byte=%0d got=%b exp=%b", n, rOr, e.g); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_timeout();
        test_ack_idle();
        test_reset_mid_send();
        checks++; if (sbq.size() !== 0) begin failures++; $display("[TB] FAIL scoreboard_drain got=%0d left exp=0", sbq.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, the number of requesters (2..8).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 1000000, the idle cycles allowed inside a locked message before the grant is revoked.
REQ-003 The block SHALL have port CLK  in  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET  in  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port REQ_VALID  in  NUM_REQ  per-requester byte available.
REQ-006 The block SHALL have port REQ_DATA  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 The block SHALL have port REQ_LAST  in  NUM_REQ  per-requester flag marking the final byte of a message.
REQ-008 The block SHALL have port REQ_READY  out  NUM_REQ  per-requester accept; a byte transfers on a cycle where VALID and READY are both high.
REQ-009 The block SHALL have port TX_DATA  out  8  byte presented to the UART core.
REQ-010 The block SHALL have port TX_STB  out  1  strobe to the UART core; held high until acknowledged.
REQ-011 The block SHALL have port TX_ACK  in  1  UART core has taken TX_DATA.
REQ-012 The block SHALL have port GRANT  out  NUM_REQ  one-hot current owner; all zero when idle.
REQ-013 The block SHALL have port BUSY  out  1  high whenever the state is not IDLE.
REQ-014 The block SHALL have port TIMEOUT  out  1  one-cycle pulse when a locked grant is revoked.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND and NEXT.
REQ-016 In IDLE, REQ_READY SHALL be combinational: it is high only for the round-robin winner among the asserted REQ_VALID bits, with the search starting at last_owner+1 mod NUM_REQ.
REQ-017 On an IDLE transfer, the block SHALL register TX_DATA from the winner, set TX_STB=1, set owner=winner, set locked=!REQ_LAST[winner], and enter SEND on the next cycle (one-cycle latency from transfer to TX_STB).
REQ-018 In SEND, all REQ_READY SHALL be 0, TX_DATA SHALL be stable, and TX_STB SHALL stay 1 until TX_ACK is sampled high.
REQ-019 On TX_ACK in SEND, TX_STB SHALL go to 0 on the next cycle; if locked, the next state SHALL be NEXT; otherwise it SHALL be IDLE with last_owner=owner.
REQ-020 TX_ACK SHALL be ignored outside SEND.
REQ-021 In NEXT, only REQ_READY[owner] SHALL be high; a transfer SHALL behave as in REQ-017 with the same owner, and other requesters SHALL be starved.
REQ-022 In NEXT, a cycle counter SHALL increment while REQ_VALID[owner] is 0 and SHALL clear on entry to NEXT.
REQ-023 When the counter reaches LOCK_TIMEOUT-1, the block SHALL go to IDLE, set last_owner=owner, and pulse TIMEOUT for one cycle.
REQ-024 If a transfer and counter expiry coincide in NEXT, the transfer SHALL win and no TIMEOUT SHALL be issued.
REQ-025 GRANT SHALL be one-hot of owner in SEND and NEXT, and 0 in IDLE.
REQ-026 Bytes SHALL reach TX_DATA in the order they were accepted; no byte SHALL be dropped or duplicated.
REQ-027 The counter width SHALL be clog2(LOCK_TIMEOUT); the round-robin index SHALL wrap modulo NUM_REQ.

Reset
REQ-028 While RESET is high, the block SHALL force state=IDLE, TX_STB=0, TX_DATA=0x00, GRANT=0, BUSY=0, TIMEOUT=0, locked=0, counter=0 and last_owner=NUM_REQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-SEND SHALL drop TX_STB immediately (asynchronously); the in-flight byte is abandoned and the requester is not re-notified.

Structure
REQ-030 The state encoding (IDLE=2'd0, SEND=2'd1, NEXT=2'd2) and the default values of NUM_REQ and LOCK_TIMEOUT SHALL live in the shared package machv_uart_pkg.
REQ-031 Round-robin winner selection SHALL be a purely combinational sub-module, machv_rr_pick (inputs: request vector and start index; outputs: one-hot winner and valid).

Verification
REQ-032 Bench: after reset, REQ_VALID=2'b11, REQ_DATA={0x42,0x41}, LAST=2'b11, TX_ACK 3 cycles after each STB -> TX_DATA sequence 0x41 then 0x42; GRANT 01 then 10.
REQ-033 Bench: requester 0 sends "ABC" with LAST only on 'C' while requester 1 holds VALID -> TX_DATA A,B,C strictly before requester 1's byte; REQ_READY[1] stays 0 throughout.
REQ-034 Bench: LOCK_TIMEOUT=16, requester 0 sends one byte with LAST=0 then drops VALID -> TIMEOUT pulses exactly 16 cycles after NEXT entry; BUSY=0 next cycle; requester 1 granted.
REQ-035 Bench: TX_ACK held high while idle, then VALID[0] with 0x55 -> TX_STB rises one cycle after the transfer and falls the cycle after the first sampled ACK, exactly one byte sent.
REQ-036 Bench: assert RESET two cycles into SEND -> TX_STB=0 and GRANT=0 within the reset cycle; after release, requester 0 wins first.
